// File: rtl/ecc_op_controller.sv
// ECC operation sequencer: snapshots the APB registers on start and runs the encoder/decoder handshakes.
// Optional watchdog is enabled by defining ECC_CTRL_TIMEOUT_EN.
module ecc_op_controller #(
    parameter int AMBA_WORD      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] ctrl,
    input  logic [AMBA_WORD-1:0] codeword_width,
    input  logic [AMBA_WORD-1:0] data_in,
    input  logic [AMBA_WORD-1:0] noise,
    output logic                 enc_req,
    output logic [AMBA_WORD-1:0] enc_data,
    input  logic                 enc_ack,
    input  logic [AMBA_WORD-1:0] enc_codeword,
    output logic                 dec_req,
    output logic [AMBA_WORD-1:0] dec_data,
    input  logic                 dec_ack,
    input  logic [AMBA_WORD-1:0] dec_result,
    input  logic [1:0]           dec_num_err,
    output logic [AMBA_WORD-1:0] data_out,
    output logic [1:0]           num_of_errors,
    output logic                 operation_done,
    output logic                 busy,
    output logic                 cmd_error,
    output logic                 timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_DEC,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        MODE_ENC  = 2'b00,
        MODE_DEC  = 2'b01,
        MODE_FULL = 2'b10,
        MODE_BAD  = 2'b11
    } mode_t;

    state_t                 state;
    state_t                 state_next;
    mode_t                  mode_q;
    logic [1:0]             width_q;
    logic [AMBA_WORD-1:0]   data_q;
    logic [AMBA_WORD-1:0]   noise_q;
    logic [AMBA_WORD-1:0]   cw_q;
    logic [AMBA_WORD-1:0]   mask;
    logic                   wd_expire;
    logic                   start_illegal;
    logic                   unused_bits;

    // Only the low two bits of the mode and width registers carry meaning.
    assign unused_bits = ^{ctrl[AMBA_WORD-1:2], codeword_width[AMBA_WORD-1:2]};

    always_comb begin
        unique case (width_q)
            2'b00:   mask = {{(AMBA_WORD-8){1'b0}}, 8'hFF};
            2'b01:   mask = {{(AMBA_WORD-16){1'b0}}, 16'hFFFF};
            default: mask = '1;
        endcase
    end

    assign start_illegal = (ctrl[1:0] == MODE_BAD) || (codeword_width[1:0] == 2'b11);

    assign enc_req        = (state == S_ENC);
    assign dec_req        = (state == S_DEC);
    assign operation_done = (state == S_DONE);
    assign cmd_error      = (state == S_ERR);
    assign busy           = (state == S_ENC) || (state == S_DEC) || (state == S_DONE);
    assign enc_data       = data_q & mask;
    // In full-channel mode the decoder sees the stored codeword corrupted by the noise pattern.
    assign dec_data       = ((mode_q == MODE_FULL) ? (cw_q ^ noise_q) : data_q) & mask;

`ifdef ECC_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_q;
    logic             waiting;

    assign waiting   = (enc_req && !enc_ack) || (dec_req && !dec_ack);
    assign wd_expire = waiting && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_expire;
            if (state_next != state) begin
                wd_cnt <= '0;
            end else if (waiting) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign wd_expire          = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        // NOTE: next state defaults to the current state so no path through the case infers a latch.
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (start_illegal) begin
                        state_next = S_ERR;
                    end else if (ctrl[1:0] == MODE_DEC) begin
                        state_next = S_DEC;
                    end else begin
                        state_next = S_ENC;
                    end
                end
            end
            S_ENC: begin
                if (wd_expire) begin
                    state_next = S_IDLE;
                end else if (enc_ack) begin
                    state_next = (mode_q == MODE_FULL) ? S_DEC : S_DONE;
                end
            end
            S_DEC: begin
                if (wd_expire) begin
                    state_next = S_IDLE;
                end else if (dec_ack) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments and a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            mode_q        <= MODE_ENC;
            width_q       <= 2'b00;
            data_q        <= '0;
            noise_q       <= '0;
            cw_q          <= '0;
            data_out      <= '0;
            num_of_errors <= 2'b00;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start) begin
                mode_q  <= mode_t'(ctrl[1:0]);
                width_q <= codeword_width[1:0];
                data_q  <= data_in;
                noise_q <= noise;
            end
            if (state == S_ENC && enc_ack) begin
                cw_q <= enc_codeword & mask;
                if (mode_q == MODE_ENC) begin
                    data_out      <= enc_codeword & mask;
                    num_of_errors <= 2'b00;
                end
            end
            if (state == S_DEC && dec_ack) begin
                data_out      <= dec_result & mask;
                num_of_errors <= dec_num_err;
            end
        end
    end

endmodule

// File: tb/tb_ecc_op_controller.sv
// Directed bench for ecc_op_controller; outputs are sampled 1 time unit after each rising edge.
module tb_ecc_op_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] ctrl;
    logic [31:0] codeword_width;
    logic [31:0] data_in;
    logic [31:0] noise;
    logic        enc_req;
    logic [31:0] enc_data;
    logic        enc_ack;
    logic [31:0] enc_codeword;
    logic        dec_req;
    logic [31:0] dec_data;
    logic        dec_ack;
    logic [31:0] dec_result;
    logic [1:0]  dec_num_err;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        operation_done;
    logic        busy;
    logic        cmd_error;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    ecc_op_controller #(.AMBA_WORD(32), .TIMEOUT_CYCLES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ctrl           (ctrl),
        .codeword_width (codeword_width),
        .data_in        (data_in),
        .noise          (noise),
        .enc_req        (enc_req),
        .enc_data       (enc_data),
        .enc_ack        (enc_ack),
        .enc_codeword   (enc_codeword),
        .dec_req        (dec_req),
        .dec_data       (dec_data),
        .dec_ack        (dec_ack),
        .dec_result     (dec_result),
        .dec_num_err    (dec_num_err),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .operation_done (operation_done),
        .busy           (busy),
        .cmd_error      (cmd_error),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enc_req"}, 32'(enc_req), 32'd0);
        check({tag, "_dec_req"}, 32'(dec_req), 32'd0);
        check({tag, "_enc_data"}, enc_data, 32'd0);
        check({tag, "_dec_data"}, dec_data, 32'd0);
        check({tag, "_data_out"}, data_out, 32'd0);
        check({tag, "_num_err"}, 32'(num_of_errors), 32'd0);
        check({tag, "_done"}, 32'(operation_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_error"}, 32'(cmd_error), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int n_req;
        int n_to;
        int n_done;

        rst = 1'b0; start = 1'b0; ctrl = '0; codeword_width = '0; data_in = '0; noise = '0;
        enc_ack = 1'b0; enc_codeword = '0; dec_ack = 1'b0; dec_result = '0; dec_num_err = 2'd0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Encode, 8-bit, ack three cycles after the request rises.
        ctrl = 32'h0; codeword_width = 32'h0; data_in = 32'h1234_56A5; start = 1'b1;
        tick();
        start = 1'b0;
        check("enc_req_up", 32'(enc_req), 32'd1);
        check("enc_data_8b", enc_data, 32'h0000_00A5);
        check("enc_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("enc_req_held", 32'(enc_req), 32'd1);
        check("enc_data_held", enc_data, 32'h0000_00A5);
        tick();
        enc_ack = 1'b1; enc_codeword = 32'hFFFF_FF3C;
        tick();
        enc_ack = 1'b0;
        check("enc_done", 32'(operation_done), 32'd1);
        check("enc_data_out", data_out, 32'h0000_003C);
        check("enc_num_err", 32'(num_of_errors), 32'd0);
        check("enc_req_drop", 32'(enc_req), 32'd0);
        tick();
        check("enc_done_pulse", 32'(operation_done), 32'd0);
        check("enc_busy_low", 32'(busy), 32'd0);
        check("enc_out_hold", data_out, 32'h0000_003C);

        // Decode, 16-bit, ack already high (ignored while idle) so it completes at T+2.
        ctrl = 32'h1; codeword_width = 32'h1; data_in = 32'hABCD_1357;
        dec_result = 32'h0000_0057; dec_num_err = 2'd1; dec_ack = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("dec_req_up", 32'(dec_req), 32'd1);
        check("dec_enc_req", 32'(enc_req), 32'd0);
        check("dec_data_16b", dec_data, 32'h0000_1357);
        check("dec_not_done_t1", 32'(operation_done), 32'd0);
        tick();
        dec_ack = 1'b0;
        check("dec_done_t2", 32'(operation_done), 32'd1);
        check("dec_data_out", data_out, 32'h0000_0057);
        check("dec_num_err", 32'(num_of_errors), 32'd1);
        tick();
        check("dec_done_pulse", 32'(operation_done), 32'd0);

        // Full channel, 32-bit, zero-wait acks on both sides.
        ctrl = 32'h2; codeword_width = 32'h2; data_in = 32'h0000_0005; noise = 32'h0000_0001;
        enc_codeword = 32'hF0F0_F0F0; enc_ack = 1'b1;
        dec_result = 32'h0000_0005; dec_num_err = 2'd1; dec_ack = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("fc_t1_enc_req", 32'(enc_req), 32'd1);
        check("fc_t1_dec_req", 32'(dec_req), 32'd0);
        check("fc_enc_data", enc_data, 32'h0000_0005);
        tick();
        check("fc_t2_enc_req", 32'(enc_req), 32'd0);
        check("fc_t2_dec_req", 32'(dec_req), 32'd1);
        check("fc_dec_data", dec_data, 32'hF0F0_F0F1);
        check("fc_t2_done", 32'(operation_done), 32'd0);
        tick();
        enc_ack = 1'b0; dec_ack = 1'b0;
        check("fc_t3_done", 32'(operation_done), 32'd1);
        check("fc_t3_dec_req", 32'(dec_req), 32'd0);
        check("fc_data_out", data_out, 32'h0000_0005);
        check("fc_num_err", 32'(num_of_errors), 32'd1);
        tick();

        // Illegal mode, then illegal width.
        ctrl = 32'h3; codeword_width = 32'h0; start = 1'b1;
        tick();
        start = 1'b0;
        check("bad_mode_cmd_error", 32'(cmd_error), 32'd1);
        check("bad_mode_reqs", 32'({enc_req, dec_req}), 32'd0);
        check("bad_mode_busy", 32'(busy), 32'd0);
        check("bad_mode_done", 32'(operation_done), 32'd0);
        check("bad_mode_data_out", data_out, 32'h0000_0005);
        tick();
        check("bad_mode_pulse", 32'(cmd_error), 32'd0);
        ctrl = 32'h0; codeword_width = 32'h3; start = 1'b1;
        tick();
        start = 1'b0;
        check("bad_width_cmd_error", 32'(cmd_error), 32'd1);
        check("bad_width_reqs", 32'({enc_req, dec_req}), 32'd0);
        check("bad_width_data_out", data_out, 32'h0000_0005);
        tick();
        check("bad_width_pulse", 32'(cmd_error), 32'd0);

        // Stalled full-channel op: second start and register changes are ignored, then reset mid-DEC.
        ctrl = 32'h2; codeword_width = 32'h0; data_in = 32'h0000_01C3; noise = 32'h0000_000F; start = 1'b1;
        tick();
        check("stall_enc_data", enc_data, 32'h0000_00C3);
        ctrl = 32'h1; codeword_width = 32'h2; data_in = 32'hFFFF_FFFF; noise = 32'hFFFF_0000;
        tick();
        start = 1'b0;
        check("stall_second_start", 32'(enc_req), 32'd1);
        check("stall_snapshot", enc_data, 32'h0000_00C3);
        check("stall_no_dec", 32'(dec_req), 32'd0);
        tick();
        enc_ack = 1'b1; enc_codeword = 32'h0000_01AA;
        tick();
        enc_ack = 1'b0;
        check("stall_dec_req", 32'(dec_req), 32'd1);
        check("stall_dec_data", dec_data, 32'h0000_00A5);
        tick();
        rst = 1'b0;
        tick();
        check_all_zero("midrst");
        rst = 1'b1;
        tick();
        check("midrst_no_done", 32'(operation_done), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        // Normal operation after the abort.
        ctrl = 32'h0; codeword_width = 32'h1; data_in = 32'h1234_5678; start = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_enc_data", enc_data, 32'h0000_5678);
        enc_ack = 1'b1; enc_codeword = 32'hABCD_BEEF;
        tick();
        enc_ack = 1'b0;
        check("post_rst_done", 32'(operation_done), 32'd1);
        check("post_rst_data_out", data_out, 32'h0000_BEEF);
        tick();

        // Encoder never answers.
        ctrl = 32'h0; codeword_width = 32'h2; data_in = 32'h1234_5677; start = 1'b1;
        tick();
        start = 1'b0;
        n_req = 0; n_to = 0; n_done = 0;
`ifdef ECC_CTRL_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            if (enc_req) n_req++;
            if (timeout) n_to++;
            if (operation_done) n_done++;
            tick();
        end
        check("wd_req_cycles", 32'(n_req), 32'd64);
        check("wd_timeout_pulses", 32'(n_to), 32'd1);
        check("wd_no_done", 32'(n_done), 32'd0);
        check("wd_busy_low", 32'(busy), 32'd0);
        check("wd_data_out", data_out, 32'h0000_BEEF);
`else
        for (int i = 0; i < 220; i++) begin
            if (enc_req) n_req++;
            if (timeout) n_to++;
            if (operation_done) n_done++;
            tick();
        end
        check("hold_req_cycles", 32'(n_req), 32'd220);
        check("hold_no_timeout", 32'(n_to), 32'd0);
        check("hold_no_done", 32'(n_done), 32'd0);
        enc_ack = 1'b1; enc_codeword = 32'h1234_5677;
        tick();
        enc_ack = 1'b0;
        check("hold_release_done", 32'(operation_done), 32'd1);
        check("hold_release_data", data_out, 32'h1234_5677);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
